// File: rtl/alu_pkg.sv
// Shared ALU function codes and execute-unit state encoding.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package alu_pkg;

    typedef logic [3:0] alufn_t;

    localparam alufn_t ALUFN_ADD  = 4'b0000;
    localparam alufn_t ALUFN_SUB  = 4'b0001;
    localparam alufn_t ALUFN_PASS = 4'b0011;
    localparam alufn_t ALUFN_OR   = 4'b0100;
    localparam alufn_t ALUFN_AND  = 4'b0101;
    localparam alufn_t ALUFN_XOR  = 4'b0111;
    localparam alufn_t ALUFN_SLL  = 4'b1000;
    localparam alufn_t ALUFN_SRL  = 4'b1001;
    localparam alufn_t ALUFN_SRA  = 4'b1010;
    localparam alufn_t ALUFN_SLT  = 4'b1101;
    localparam alufn_t ALUFN_SLTU = 4'b1111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } exec_state_t;

    // True for the three codes that go through the iterative shifter.
    function automatic logic is_shift(input alufn_t fn);
        return (fn == ALUFN_SLL) || (fn == ALUFN_SRL) || (fn == ALUFN_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: shift left or right by amt with a fill bit.
// Latency: combinational.
// Backpressure: none; the caller sequences iterations.
module alu_shift_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      amt,
    input  logic            dir_left,
    input  logic            fill,
    output logic [XLEN-1:0] data_out
);

    logic [XLEN-1:0] fill_mask;

    // Right shifts OR the fill bit into the vacated upper positions.
    always_comb begin
        fill_mask = ~({XLEN{1'b1}} >> amt) & {XLEN{fill}};
        if (dir_left) begin
            data_out = data_in << amt;
        end else begin
            data_out = (data_in >> amt) | fill_mask;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute unit: single-cycle logic/add/compare, iterative shifts, registered result and flags.
// Latency: 1 edge for single-cycle ops and zero shifts, 1 + ceil(n/SHIFT_PER_CYCLE) edges for shifts.
// Backpressure: in_ready drops while shifting or while a result is held with out_ready low.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alufn,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_c,
    output logic            flag_v
);

    localparam logic [4:0] SPC_AMT = 5'(SHIFT_PER_CYCLE);

    exec_state_t     state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;      // {z, n, c, v}
    logic [XLEN-1:0] work_q, work_d;
    logic [4:0]      remain_q, remain_d;
    logic            dir_left_q, dir_left_d;
    logic            fill_q, fill_d;

    logic [XLEN:0]   sum_ext, diff_ext;
    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v, alu_def;
    logic [4:0]      step_amt;
    logic [XLEN-1:0] shift_out;
    logic            accept;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign {flag_z, flag_n, flag_c, flag_v} = flags_q;

    // Single-cycle datapath: adder, subtractor, compares, logic, and the zero-shift case.
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_def  = 1'b1;
        case (alufn)
            ALUFN_ADD: begin
                alu_res = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
                alu_v   = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum_ext[XLEN-1] != op_a[XLEN-1]);
            end
            ALUFN_SUB: begin
                alu_res = diff_ext[XLEN-1:0];
                alu_c   = diff_ext[XLEN];
                alu_v   = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff_ext[XLEN-1] != op_a[XLEN-1]);
            end
            ALUFN_PASS: alu_res = op_b;
            ALUFN_OR:   alu_res = op_a | op_b;
            ALUFN_AND:  alu_res = op_a & op_b;
            ALUFN_XOR:  alu_res = op_a ^ op_b;
            ALUFN_SLL, ALUFN_SRL, ALUFN_SRA: alu_res = op_a;   // only reached with shamt 0
            ALUFN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALUFN_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:    alu_def = 1'b0;
        endcase
    end

    // Each iteration moves min(SHIFT_PER_CYCLE, remaining) positions.
    always_comb begin
        if (int'(remain_q) < SHIFT_PER_CYCLE) begin
            step_amt = remain_q;
        end else begin
            step_amt = SPC_AMT;
        end
    end

    alu_shift_step #(.XLEN(XLEN)) u_shift_step (
        .data_in  (work_q),
        .amt      (step_amt),
        .dir_left (dir_left_q),
        .fill     (fill_q),
        .data_out (shift_out)
    );

    // Next-state: accept work in IDLE, iterate in SHIFT, manage the output holding register.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        work_d      = work_q;
        remain_d    = remain_q;
        dir_left_d  = dir_left_q;
        fill_d      = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift(alufn) && (op_b[4:0] != 5'd0)) begin
                        state_d     = ST_SHIFT;
                        work_d      = op_a;
                        remain_d    = op_b[4:0];
                        dir_left_d  = (alufn == ALUFN_SLL);
                        fill_d      = (alufn == ALUFN_SRA) && op_a[XLEN-1];
                        out_valid_d = 1'b0;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = {alu_def && (alu_res == '0), alu_def && alu_res[XLEN-1], alu_c, alu_v};
                        out_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                work_d   = shift_out;
                remain_d = remain_q - step_amt;
                if (remain_d == 5'd0) begin
                    result_d    = shift_out;
                    flags_d     = {(shift_out == '0), shift_out[XLEN-1], 1'b0, 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any in-flight shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            work_q      <= '0;
            remain_q    <= '0;
            dir_left_q  <= 1'b0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            work_q      <= work_d;
            remain_q    <= remain_d;
            dir_left_q  <= dir_left_d;
            fill_q      <= fill_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit with a behavioural reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and simultaneous consume/accept.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alufn = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_z, flag_n, flag_c, flag_v;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHIFT_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alufn     (alufn),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {result, z, n, c, v} from plain arithmetic on the operation's meaning.
    function automatic logic [35:0] model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [32:0] w;
        logic        c, v, def;
        longint      sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; c = 1'b0; v = 1'b0; def = 1'b1;
        case (fn)
            4'b0000: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0001: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0011: r = b;
            4'b0100: r = a | b;
            4'b0101: r = a & b;
            4'b0111: r = a ^ b;
            4'b1000: r = a << b[4:0];
            4'b1001: r = a >> b[4:0];
            4'b1010: r = $signed(a) >>> b[4:0];
            4'b1101: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1111: r = (a < b) ? 32'd1 : 32'd0;
            default: def = 1'b0;
        endcase
        return {r, def && (r == 32'd0), def && r[31], c, v};
    endfunction

    function automatic int model_lat(input logic [3:0] fn, input logic [31:0] b);
        if ((fn == 4'b1000 || fn == 4'b1001 || fn == 4'b1010) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Presents one op with out_ready high and collects what comes back (no checking here).
    task automatic run_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] fl, output int lat, output int low);
        alufn = fn; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        alufn = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1; low = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) low++;
            step();
            lat++;
        end
        res = result;
        fl  = {flag_z, flag_n, flag_c, flag_v};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_cmp++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [3:0]  t_fn  [9] = '{4'b0000, 4'b0001, 4'b1111, 4'b1101, 4'b1010, 4'b1000, 4'b0010, 4'b0011, 4'b0001};
        logic [31:0] t_a   [9] = '{32'h7FFF_FFFF, 32'd5, 32'd1, 32'd1, 32'h8000_0000, 32'd1, 32'h1234_5678, 32'd0, 32'd0};
        logic [31:0] t_b   [9] = '{32'd1, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd31, 32'd0, 32'd9, 32'hDEAD_BEEF, 32'd1};
        logic [31:0] t_res [9] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        logic [3:0]  t_fl  [9] = '{4'b0101, 4'b1010, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        int          t_lat [9] = '{1, 1, 1, 1, 32, 1, 1, 1, 1};
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat, low;
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
            run_op(t_fn[i], t_a[i], t_b[i], res, fl, lat, low);
            n_cmp++;
            if (res !== t_res[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, res, t_res[i]); end
            n_cmp++;
            if (fl !== t_fl[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", i, fl, t_fl[i]); end
            n_cmp++;
            if (lat !== t_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, t_lat[i]); end
            n_cmp++;
            if (low !== t_lat[i] - 1) begin n_fail++; $display("FAIL dir%0d_in_ready_low: got %0d expected %0d", i, low, t_lat[i] - 1); end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
        logic [3:0]  fn;
        logic [31:0] a, b, res;
        logic [3:0]  fl;
        logic [35:0] exp;
        int          lat, low;
        for (int i = 0; i < 60; i++) begin
            fn = 4'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            exp = model(fn, a, b);
            run_op(fn, a, b, res, fl, lat, low);
            n_cmp++;
            if ({res, fl} !== exp) begin
                n_fail++;
                $display("FAIL rnd%0d_fn%b: got %h/%b expected %h/%b", i, fn, res, fl, exp[35:4], exp[3:0]);
            end
            n_cmp++;
            if (lat !== model_lat(fn, b)) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, model_lat(fn, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [3:0]  fn;
        logic [3:0]  codes [6] = '{4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1101, 4'b1111};
        logic [35:0] exp;
        step();
        // A result left pending while the consumer stalls.
        out_ready = 1'b0;
        alufn = 4'b0000; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
        step();
        alufn = 4'b0001; op_a = 32'd100; op_b = 32'd1;   // must be ignored while stalled
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 32'd7}) begin
                n_fail++; $display("FAIL stall%0d: got rdy=%b vld=%b res=%h expected rdy=0 vld=1 res=7", i, in_ready, out_valid, result);
            end
            step();
        end
        // Release the stall while presenting a new op in the same cycle.
        out_ready = 1'b1;
        alufn = 4'b0000; op_a = 32'd10; op_b = 32'd20;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        step();
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'd30}) begin
            n_fail++; $display("FAIL release_result: got vld=%b res=%h expected vld=1 res=1e", out_valid, result);
        end
        // Throughput of one single-cycle op per cycle.
        for (int i = 0; i < 10; i++) begin
            fn = codes[$urandom_range(0, 5)];
            a = $urandom; b = $urandom;
            exp = model(fn, a, b);
            alufn = fn; op_a = a; op_b = b;
            step();
            n_cmp++;
            if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== {1'b1, exp}) begin
                n_fail++; $display("FAIL b2b%0d: got vld=%b %h expected %h", i, out_valid, result, exp[35:4]);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat, low;
        alufn = 4'b0111; op_a = 32'hA5A5_0000; op_b = 32'h0000_1234; in_valid = 1'b1; out_ready = 1'b1;
        step();
        alufn = 4'b1001; op_a = 32'hF0F0_0000; op_b = 32'd20;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midshift_busy: got %b expected 0", in_ready); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== 37'd0) begin
            n_fail++; $display("FAIL midshift_reset: got vld=%b res=%h expected vld=0 res=0", out_valid, result);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midshift_in_ready: got %b expected 1", in_ready); end
        run_op(4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, res, fl, lat, low);
        n_cmp++;
        if ({res, fl, lat} !== {32'hF00F_F00F, 4'b0100, 32'd1}) begin
            n_fail++; $display("FAIL post_reset_xor: got %h/%b lat %0d expected f00ff00f/0100 lat 1", res, fl, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle ALU execute unit for the RV32I multi-cycle core variant: consumes the 4-bit `alufn` code produced by the ALU control decoder plus two operands and returns a registered result and branch flags. Logic ops, add/sub and compares complete in one cycle. Shifts run iteratively to save area. Sits between the register-read stage and writeback/branch resolution, using valid/ready handshakes on both sides.

## Interface
- `XLEN`, default 32: operand/result width.
- `SHIFT_PER_CYCLE`, default 1: bit positions shifted per iteration; power of two, 1..XLEN.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept this cycle.
- `alufn`  in  4  operation code, encoding below.
- `op_a`  in  XLEN  operand A (rs1/PC).
- `op_b`  in  XLEN  operand B (rs2/imm); shift amount is `op_b[4:0]`.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative, carry, overflow.

## Operation
- Encoding: 0000 ADD, 0001 SUB, 0011 PASS (result = op_b), 0100 OR, 0101 AND, 0111 XOR, 1000 SLL, 1001 SRL, 1010 SRA, 1101 SLT, 1111 SLTU. Any other code: result = 0, all flags 0.
- SLT/SLTU: result = {XLEN-1 zeros, lt}. Signed compare for SLT, unsigned for SLTU.
- Flags: `flag_z` = (result == 0), `flag_n` = result[XLEN-1] for every defined op.
- For ADD/SUB only: `flag_c` = carry out of the XLEN-bit adder. SUB computes a + ~b + 1, so c=1 means a >= b unsigned. `flag_v` = signed overflow. For all other ops, c = v = 0.
- States:
  - IDLE: waiting for work.
  - SHIFT: iterating a shift.
  - A separate `out_valid` register holds the result until it is consumed.
- Accept: `in_valid && in_ready`. `in_ready` = (state == IDLE) && (!out_valid || out_ready).
- Non-shift op, or shift with shamt 0: result and flags are written at the accept edge and `out_valid` is set. State stays IDLE.
- Shift with shamt n > 0, on accept:
  - Load the working register with op_a and the remaining count with n.
  - Go to SHIFT.
  - Each SHIFT cycle shifts by min(SHIFT_PER_CYCLE, remaining) and decrements remaining by the same amount.
  - SRA fills with the original op_a[XLEN-1]. SLL and SRL fill with 0.
  - When remaining reaches 0: write result and flags, set `out_valid`, return to IDLE.
- Output: `result` and flags stay stable while `out_valid && !out_ready`. `out_valid` clears on `out_ready`, unless a new single-cycle op is accepted in the same cycle, in which case it stays high with the new data.
- Inputs are ignored while `in_ready` = 0. The operands of an in-flight shift are captured internally, not re-read.

## Timing
- Reset (rst_n low at a clk edge, any state, including mid-shift): state IDLE, `out_valid` 0, `result` 0, all flags 0. The in-flight shift is discarded. `in_ready` is 1 in the first cycle after reset deassert.
- Single-cycle ops: latency 1. Accept at edge E0, `out_valid` high after E0. Throughput 1/cycle while `out_ready` = 1.
- Shifts: latency 1 + ceil(n / SHIFT_PER_CYCLE) edges after accept. `in_ready` = 0 throughout SHIFT.
- Simultaneous `out_ready` and accept: old result consumed and new one loaded at the same edge. No bubble, no loss.

## Structure
- Package `alu_pkg`: `alufn_t` (4-bit) and named constants for all eleven codes, shared with the ALU control decoder and this unit.
- Sub-module `alu_shift_step`: combinational shift of one iteration (direction, arithmetic fill, amount ≤ SHIFT_PER_CYCLE). Instantiated once.
- Adder, compare and logic stay in the top module.

## Test plan
- ADD 0x7FFF_FFFF + 1, out_ready = 1 → result 0x8000_0000 one cycle later; n=1, v=1, c=0, z=0.
- SUB 5 − 5 → result 0, z=1, c=1, v=0. SLTU 1 vs 0xFFFF_FFFF → result 1. SLT on the same operands → result 0.
- SRA 0x8000_0000 by 31, SHIFT_PER_CYCLE = 1 → `out_valid` 32 edges after accept, result 0xFFFF_FFFF; `in_ready` low for 31 cycles.
- SLL 1 by 0 → 1-cycle latency, result 1. Undefined code 0010 → result 0, all flags 0.
- Hold `out_ready` = 0 with a result pending → `in_ready` 0 and outputs stable. Raise `out_ready` with a new ADD presented in the same cycle → back-to-back results, none dropped.
- Assert rst_n = 0 mid-SRL (after 3 iterations) → next cycle state IDLE, `out_valid` 0, `result` 0; a following XOR completes normally.
